// File: rtl/std_fp_mac_pipe.sv
// Unsigned fixed-point multiply-accumulate: two-stage product pipeline feeding a
// wide accumulator, emitting one saturated WIDTH-bit result per vector.
module std_fp_mac_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned INT_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 16,
  parameter int unsigned GUARD_BITS = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     left,
  input  logic [WIDTH-1:0]     right,
  output logic [WIDTH-1:0]     out,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 sat,
  output logic                 done
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned ACC_W  = PROD_W + GUARD_BITS;
  localparam int unsigned OUT_HI = WIDTH + FRAC_WIDTH;

  if (WIDTH != INT_WIDTH + FRAC_WIDTH) begin : g_bad_format
    $error("std_fp_mac_pipe: WIDTH must equal INT_WIDTH + FRAC_WIDTH");
  end

  logic                 s1_valid_q, s1_last_q;
  logic [WIDTH-1:0]     s1_left_q, s1_right_q;
  logic                 s2_valid_q, s2_last_q;
  logic [PROD_W-1:0]    s2_prod_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic [ACC_W:0]       acc_sum;
  logic                 close;
  logic                 saturate;
  logic [WIDTH-1:0]     out_q;
  logic [CNT_WIDTH-1:0] out_count_q;
  logic                 sat_q, done_q;

  // Next accumulator/counter/sticky state for the term sitting in S2.
  // A zero counter marks an empty accumulator, since the counter never wraps back to 0.
  always_comb begin
    acc_sum  = {1'b0, acc_q} + {{(GUARD_BITS + 1){1'b0}}, s2_prod_q};
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (cnt_q == '0) begin
      acc_d    = {{GUARD_BITS{1'b0}}, s2_prod_q};
      cnt_d    = CNT_WIDTH'(1);
      sticky_d = 1'b0;
    end else begin
      acc_d    = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
      cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      sticky_d = sticky_q | acc_sum[ACC_W];
    end
    close    = s2_valid_q & s2_last_q & ~clear;
    saturate = (|acc_d[ACC_W-1:OUT_HI]) | sticky_d;
  end

  // S1: register operands; clear kills any pair accepted on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_left_q  <= '0;
      s1_right_q <= '0;
    end else begin
      s1_valid_q <= in_valid & ~clear;
      s1_last_q  <= in_valid & in_last;
      if (in_valid) begin
        s1_left_q  <= left;
        s1_right_q <= right;
      end
    end
  end

  // S2: register the full-width product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q & ~clear;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q) begin
        s2_prod_q <= PROD_W'(s1_left_q) * PROD_W'(s1_right_q);
      end
    end
  end

  // Accumulator: empties on clear or on close, otherwise folds in each S2 term.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (clear || close) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (s2_valid_q) begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // Result registers: truncate to the input format or clamp, pulse done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      out_count_q <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= close;
      if (close) begin
        out_q       <= saturate ? {WIDTH{1'b1}} : acc_d[OUT_HI-1:FRAC_WIDTH];
        out_count_q <= cnt_d;
        sat_q       <= saturate;
      end
    end
  end

  assign out       = out_q;
  assign out_count = out_count_q;
  assign sat       = sat_q;
  assign done      = done_q;

endmodule
